// File: rtl/ili9488_byte_sequencer.sv
// ili9488_byte_sequencer: FIFO-buffered command/data byte pacer feeding the ILI9488 SPI serialiser.
// Define SEQ_DELAY_EN to make kind-10 entries timed delays instead of discarded entries.
module ili9488_byte_sequencer #(
  parameter int DEPTH       = 4,
  parameter int BYTE_CYCLES = 9,
  parameter int GAP_CYCLES  = 2,
  parameter int DELAY_UNIT  = 1000
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_kind,
  input  logic [7:0]                 in_byte,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       busy_out,
  output logic                       send_data_out,
  output logic [7:0]                 data_byte_out,
  output logic                       dc_out
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int M1 = BYTE_CYCLES > GAP_CYCLES ? BYTE_CYCLES : GAP_CYCLES;
  localparam int M2 = M1 > 256 * DELAY_UNIT ? M1 : 256 * DELAY_UNIT;
  localparam int CW = $clog2(M2 + 1);
`ifdef SEQ_DELAY_EN
  typedef enum logic [1:0] {IDLE, SEND, GAP, DELAY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`endif
  logic [9:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic          r_full;
  logic [CW-1:0] r_cnt, w_cnt;
  state_t        r_state, w_state;
  logic          w_push, w_pop, w_send, w_dc;
  logic [7:0]    w_byte;
  logic [9:0]    w_head;
  logic [LW-1:0] w_level;
  assign in_ready = !r_full;
  assign w_push   = in_valid && !r_full;
  assign w_pop    = r_state == IDLE && fifo_level != '0;
  assign w_head   = r_mem[r_rd];
  assign w_level  = fifo_level + LW'(w_push) - LW'(w_pop);
  assign busy_out = r_state != IDLE || fifo_level != '0;
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_send  = send_data_out;
    w_byte  = data_byte_out;
    w_dc    = dc_out;
    case (r_state)
      IDLE: if (w_pop) begin
        if (!w_head[9]) begin
          w_state = SEND;
          w_cnt   = CW'(BYTE_CYCLES - 1);
          w_send  = 1'b1;
          w_byte  = w_head[7:0];
          w_dc    = w_head[8];
        end
`ifdef SEQ_DELAY_EN
        else if (!w_head[8]) begin
          w_state = DELAY;
          w_cnt   = w_head[7:0] == '0 ? '0 : CW'(w_head[7:0]) * CW'(DELAY_UNIT) - CW'(1);
        end
`endif
        else begin
          w_state = GAP;
          w_cnt   = CW'(GAP_CYCLES - 1);
        end
      end
      SEND: begin
        w_state = r_cnt == '0 ? GAP : SEND;
        w_cnt   = r_cnt == '0 ? CW'(GAP_CYCLES - 1) : r_cnt - CW'(1);
        w_send  = r_cnt != '0;
      end
      GAP: begin
        w_state = r_cnt == '0 ? IDLE : GAP;
        w_cnt   = r_cnt == '0 ? r_cnt : r_cnt - CW'(1);
      end
`ifdef SEQ_DELAY_EN
      DELAY: begin
        w_state = r_cnt == '0 ? GAP : DELAY;
        w_cnt   = r_cnt == '0 ? CW'(GAP_CYCLES - 1) : r_cnt - CW'(1);
      end
`endif
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      send_data_out <= 1'b0;
      data_byte_out <= 8'h00;
      dc_out        <= 1'b0;
      r_wr          <= '0;
      r_rd          <= '0;
      fifo_level    <= '0;
      r_full        <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      send_data_out <= w_send;
      data_byte_out <= w_byte;
      dc_out        <= w_dc;
      r_wr          <= r_wr + PW'(w_push);
      r_rd          <= r_rd + PW'(w_pop);
      fifo_level    <= w_level;
      r_full        <= w_level == LW'(DEPTH);
    end
  end
  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr] <= {in_kind, in_byte};
  end
endmodule
